// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg: shared types and defaults for the serial pattern detector.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W_DEF   = 4;
  localparam int CNT_W_DEF   = 8;
  localparam int MIN_LEN     = 2;

endpackage

`default_nettype wire

// File: rtl/seq_det_match.sv
// ---------------------------------------------------------------------------
// seq_det_match: shift register, fill counter and masked pattern compare.
// Rev 1.0 -- SEQ_DET_NONOVERLAP_EN flushes history after each hit.
// ---------------------------------------------------------------------------
`default_nettype none

module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               in_bit,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] shreg;
  logic [MAX_LEN-1:0] shreg_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_nxt;

  // Hit is judged on the post-shift view so the match register lags by one cycle.
  always_comb begin
    shreg_nxt = (shreg << 1) | {{(MAX_LEN-1){1'b0}}, in_bit};
    fill_nxt  = (fill == FILL_MAX) ? fill : fill + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = shift_en && (fill_nxt >= len) && (((shreg_nxt ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg <= '0;
      fill  <= '0;
    end else if (shift_en) begin
`ifdef SEQ_DET_NONOVERLAP_EN
      if (hit) begin
        shreg <= '0;
        fill  <= '0;
      end else begin
        shreg <= shreg_nxt;
        fill  <= fill_nxt;
      end
`else
      shreg <= shreg_nxt;
      fill  <= fill_nxt;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl: configurable serial pattern-detection controller.
// Rev 1.0 -- SEQ_DET_NONOVERLAP_EN selects non-overlapping detection.
// ---------------------------------------------------------------------------
`default_nettype none

module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_limit,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               cfg_ok
);

  localparam logic [LEN_W-1:0] LEN_LO = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_HI = LEN_W'(MAX_LEN);

  state_t             state;
  state_t             state_nxt;
  logic [MAX_LEN-1:0] pat_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [CNT_W-1:0]   limit_reg;
  logic [CNT_W-1:0]   cnt_inc;
  logic               cfg_take;
  logic               len_bad;
  logic               shift_en;
  logic               clear;
  logic               hit;
  logic               halt_hit;

  seq_det_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift_en (shift_en),
    .in_bit   (in_bit),
    .pattern  (pat_reg),
    .len      (len_reg),
    .hit      (hit)
  );

  // stop outranks start everywhere, and a stop cycle never shifts or matches.
  always_comb begin
    cfg_take  = cfg_valid && (state == IDLE);
    len_bad   = (cfg_len < LEN_LO) || (cfg_len > LEN_HI);
    shift_en  = (state == RUN) && in_valid && !stop;
    clear     = start && !stop && (((state == IDLE) && cfg_ok) || (state == HALT));
    cnt_inc   = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
    halt_hit  = hit && (limit_reg != '0) && (cnt_inc == limit_reg);
    state_nxt = state;
    case (state)
      IDLE:    if (clear) state_nxt = RUN;
      RUN: begin
        if (stop)          state_nxt = IDLE;
        else if (halt_hit) state_nxt = HALT;
      end
      HALT: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match     <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
      cfg_ok    <= 1'b0;
      pat_reg   <= '0;
      len_reg   <= '0;
      limit_reg <= '0;
    end else begin
      match   <= hit;
      cfg_err <= cfg_take && len_bad;
      if (cfg_take && !len_bad) begin
        pat_reg   <= cfg_pattern;
        len_reg   <= cfg_len;
        limit_reg <= cfg_limit;
        cfg_ok    <= 1'b1;
      end
      if (clear)    match_cnt <= '0;
      else if (hit) match_cnt <= cnt_inc;
    end
  end

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == HALT);

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_ctrl: directed self-checking bench for seq_detect_ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_limit;
  logic               cfg_err;
  logic               start;
  logic               stop;
  logic               in_valid;
  logic               in_bit;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
  logic               cfg_ok;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_limit   (cfg_limit),
    .cfg_err     (cfg_err),
    .start       (start),
    .stop        (stop),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .match       (match),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done),
    .cfg_ok      (cfg_ok)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                          input logic [CNT_W-1:0] lim);
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_limit = lim;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic arm;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic halt_run;
    in_valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%0b exp=1", cfg_ready); end
    checks++; if (cfg_ok !== 1'b0) begin failures++; $display("FAIL reset_cfg_ok got=%0b exp=0", cfg_ok); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%0b%0b exp=00", busy, done); end
    checks++; if (match !== 1'b0 || cfg_err !== 1'b0) begin failures++; $display("FAIL reset_match_err got=%0b%0b exp=00", match, cfg_err); end
    checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL reset_match_cnt got=%0d exp=0", match_cnt); end
  endtask

  task automatic test_overlap;
    logic [6:0] bits;
    logic [6:0] exp;
    logic [7:0] exp_cnt;
    bits = 7'b1101101;
`ifdef SEQ_DET_NONOVERLAP_EN
    exp = 7'b0001000; exp_cnt = 8'd1;
`else
    exp = 7'b0001001; exp_cnt = 8'd2;
`endif
    load_cfg(8'b0000_1101, 4'd4, 8'd0);
    checks++; if (cfg_ok !== 1'b1 || cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_accept ok/err got=%0b%0b exp=10", cfg_ok, cfg_err); end
    arm();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL arm_busy got=%0b exp=1", busy); end
    for (int i = 6; i >= 0; i--) begin
      in_valid = 1'b1; in_bit = bits[i];
      tick();
      checks++; if (match !== exp[i]) begin failures++; $display("FAIL overlap_match bit%0d got=%0b exp=%0b", 7 - i, match, exp[i]); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL overlap_match_idle got=%0b exp=0", match); end
    checks++; if (match_cnt !== exp_cnt) begin failures++; $display("FAIL overlap_cnt got=%0d exp=%0d", match_cnt, exp_cnt); end
    halt_run();
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin failures++; $display("FAIL overlap_stop busy/ready got=%0b%0b exp=01", busy, cfg_ready); end
  endtask

  task automatic test_cfg_err;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_cfg(8'h0D, 4'd1, 8'd0);
    checks++; if (cfg_err !== 1'b1 || cfg_ok !== 1'b0) begin failures++; $display("FAIL cfg_len1 err/ok got=%0b%0b exp=10", cfg_err, cfg_ok); end
    tick();
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_pulse got=%0b exp=0", cfg_err); end
    load_cfg(8'h0D, 4'(MAX_LEN + 1), 8'd0);
    checks++; if (cfg_err !== 1'b1 || cfg_ok !== 1'b0) begin failures++; $display("FAIL cfg_len_max1 err/ok got=%0b%0b exp=10", cfg_err, cfg_ok); end
    arm();
    checks++; if (busy !== 1'b0 || cfg_err !== 1'b0) begin failures++; $display("FAIL start_no_cfg busy/err got=%0b%0b exp=00", busy, cfg_err); end
  endtask

  task automatic test_limit;
    logic [6:0] bits;
    logic [6:0] exp;
    bits = 7'b1010101;
`ifdef SEQ_DET_NONOVERLAP_EN
    exp = 7'b0010001;
`else
    exp = 7'b0010100;
`endif
    load_cfg(8'b0000_0101, 4'd3, 8'd2);
    arm();
    for (int i = 6; i >= 0; i--) begin
      in_valid = 1'b1; in_bit = bits[i];
      tick();
      checks++; if (match !== exp[i]) begin failures++; $display("FAIL limit_match bit%0d got=%0b exp=%0b", 7 - i, match, exp[i]); end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL limit_halt done/busy got=%0b%0b exp=10", done, busy); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = i[0] ? 1'b0 : 1'b1;
      tick();
      checks++; if (match !== 1'b0) begin failures++; $display("FAIL halt_ignore_match cyc%0d got=%0b exp=0", i, match); end
    end
    in_valid = 1'b0;
    checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL halt_cnt got=%0d exp=2", match_cnt); end
    arm();
    checks++; if (busy !== 1'b1 || match_cnt !== 8'd0) begin failures++; $display("FAIL halt_restart busy/cnt got=%0b/%0d exp=1/0", busy, match_cnt); end
    halt_run();
  endtask

  task automatic test_gaps;
    logic [6:0] vld;
    logic [6:0] dat;
    vld = 7'b1010101;
    dat = 7'b1010001;
    load_cfg(8'b0000_1101, 4'd4, 8'd0);
    arm();
    for (int i = 6; i >= 0; i--) begin
      in_valid = vld[i]; in_bit = dat[i];
      tick();
      checks++; if (match !== (i == 0)) begin failures++; $display("FAIL gap_match cyc%0d got=%0b exp=%0b", 7 - i, match, (i == 0)); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (match !== 1'b0 || match_cnt !== 8'd1) begin failures++; $display("FAIL gap_after match/cnt got=%0b/%0d exp=0/1", match, match_cnt); end
    halt_run();
  endtask

  task automatic test_stop;
    logic [2:0] bits;
    bits = 3'b110;
    arm();
    for (int i = 2; i >= 0; i--) begin
      in_valid = 1'b1; in_bit = bits[i];
      tick();
    end
    in_valid = 1'b1; in_bit = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0; in_valid = 1'b0;
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL stop_discard match got=%0b exp=0", match); end
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin failures++; $display("FAIL stop_idle busy/ready got=%0b%0b exp=01", busy, cfg_ready); end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin failures++; $display("FAIL start_stop_idle busy/ready got=%0b%0b exp=01", busy, cfg_ready); end
  endtask

  task automatic test_reset_mid_run;
    logic [11:0] bits;
    bits = 12'b1101_1101_1101;
    load_cfg(8'b0000_1101, 4'd4, 8'd0);
    arm();
    for (int i = 11; i >= 0; i--) begin
      in_valid = 1'b1; in_bit = bits[i];
      tick();
    end
    checks++; if (match !== 1'b1 || match_cnt !== 8'd3) begin failures++; $display("FAIL pre_reset match/cnt got=%0b/%0d exp=1/3", match, match_cnt); end
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (match_cnt !== 8'd0 || match !== 1'b0) begin failures++; $display("FAIL midrun_reset cnt/match got=%0d/%0b exp=0/0", match_cnt, match); end
    checks++; if (cfg_ok !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrun_reset ok/ready/busy got=%0b%0b%0b exp=010", cfg_ok, cfg_ready, busy); end
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_limit = '0;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    test_reset();
    test_overlap();
    test_cfg_err();
    test_limit();
    test_gaps();
    test_stop();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Run-time programmable serial pattern-detection controller.
- Accepts a pattern and length over a config handshake, arms detection on `start` and samples a qualified serial bit stream.
- Emits a registered match pulse, counts matches and halts when a programmed match limit is reached.
- Sits between the register/config interface and the serial input path. It replaces fixed-pattern detector FSMs with one configurable block.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..16)
- LEN_W, 4, width of the length field; must hold MAX_LEN
- CNT_W, 8, width of the match counter and of the match limit

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  high only in IDLE
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received
- cfg_len  in  LEN_W  pattern length
- cfg_limit  in  CNT_W  match limit; 0 = unlimited
- cfg_err  out  1  one-cycle pulse when a config is rejected
- start  in  1  arm detection
- stop  in  1  abort detection
- in_valid  in  1  serial bit qualifier
- in_bit  in  1  serial data
- match  out  1  one-cycle registered match pulse
- match_cnt  out  CNT_W  matches since last start
- busy  out  1  state == RUN
- done  out  1  state == HALT
- cfg_ok  out  1  a valid config is loaded

Behaviour:
- Interface: one clock (`clk`); reset `rst` is synchronous and active-high.
- Reset: state=IDLE, match=0, match_cnt=0, cfg_err=0, cfg_ok=0, shift register=0, fill=0, pattern/len/limit registers=0.
- States:
  - IDLE: cfg_ready=1.
  - IDLE -> RUN on start && cfg_ok.
  - start without cfg_ok is ignored.
- Config handshake:
  - Accepted on cfg_valid && cfg_ready.
  - If cfg_len < 2 or cfg_len > MAX_LEN: nothing is loaded, cfg_err=1 next cycle, cfg_ok unchanged.
  - Otherwise pattern/len/limit are loaded and cfg_ok=1 next cycle.
  - cfg_valid outside IDLE is ignored.
- On IDLE -> RUN: match_cnt=0, fill=0, shift register=0.
- RUN, per in_valid cycle:
  - shreg <= {shreg[MAX_LEN-2:0], in_bit}; fill <= min(fill+1, MAX_LEN).
  - Hit condition: updated fill >= len and updated shreg[len-1:0] == pattern[len-1:0].
  - On a hit, match=1 in the cycle after the completing bit was sampled; latency 1.
  - On a hit, match_cnt increments and saturates at 2^CNT_W-1.
  - Detection is overlapping by default.
- RUN -> HALT: on the hit where limit != 0 and the incremented count == limit. That match pulse still fires.
- HALT:
  - in_valid is ignored, match_cnt is held, done=1.
  - HALT -> RUN on start, which clears count, fill and shreg.
  - HALT -> IDLE on stop.
- RUN -> IDLE on stop. The in_bit sampled with stop is discarded; no match is possible that cycle.
- Simultaneous start and stop: stop wins in every state.
- in_valid=0 cycles: no shift, no match; gaps are transparent.
- match is 0 in every cycle other than a hit cycle.
- Reset mid-RUN returns everything to reset values, including cfg_ok=0.

Optional Feature:
- Macro: SEQ_DET_NONOVERLAP_EN.
- Defined: after a hit, fill is forced to 0 and shreg to 0 in the same update. The next match therefore needs len fresh bits (non-overlapping detection).
- Undefined: overlapping detection as specified in Behaviour.

Decomposition:
- Package seq_det_pkg holds:
  - state enum {IDLE, RUN, HALT}
  - defaults for MAX_LEN, LEN_W and CNT_W
  - constant MIN_LEN=2
- Sub-module seq_det_match: shift register, fill counter and masked compare, producing a combinational hit.
- The controller FSM, config registers and counter stay in the top level.

Test Plan:
- Pattern 4'b1101, len 4, limit 0, start, stream 1,1,0,1,1,0,1 -> match after bits 4 and 7; match_cnt=2. With SEQ_DET_NONOVERLAP_EN: match after bit 4 only; match_cnt=1.
- cfg_len=1, then cfg_len=MAX_LEN+1 -> cfg_err pulses twice; cfg_ok stays 0; a following start leaves busy=0.
- Pattern 3'b101, len 3, limit 2, stream 1,0,1,0,1,0,1 -> two matches, then done=1, busy=0. Further bits produce no match; match_cnt=2 is held.
- Pattern 1101, in_valid toggling 1,0,1,0,... with bits 1,1,0,1 on the valid cycles -> exactly one match, one cycle after the 4th valid bit.
- During RUN after bits 1,1,0: stop asserted together with in_bit=1 -> no match, state IDLE. start+stop together from IDLE -> stays IDLE.
- rst asserted mid-RUN after 3 matches -> next cycle match_cnt=0, cfg_ok=0, cfg_ready=1, match=0.
